shot_annunciator: RTL and testbench

Downstream output stage of the `shot` shot-clock counter. Consumes its `count`, `shoot` and `buzz` outputs and drives the scoreboard hardware: a registered 7-segment digit for the remaining count and a timed, tone-modulated horn that fires on the expiry edge. While the horn sounds, the digit blinks. A new `shoot` edge cancels the horn.

---
 rtl/shot_pkg.sv | 34 +++
 rtl/seg7_decode.sv | 27 ++
 rtl/shot_annunciator.sv | 138 +++++++++++++
 tb/tb_shot_annunciator.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/shot_pkg.sv
// Shared types and constants for the shot-clock scoreboard output stage.
// The state encoding, the 7-segment glyphs and the counter-width helper live here.
package shot_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HORN = 2'd1,
      COOL = 2'd2
   } state_t;

   // Active-high segments, bit 0 = a ... bit 6 = g
   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   // Counter width for a modulus, never narrower than one bit
   function automatic int cnt_width(input int modulus);
      if (modulus > 1) begin
         return $clog2(modulus);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-7-segment decoder; values above 9 show a dash.
module seg7_decode
   import shot_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   // Glyph lookup
   always_comb begin
      seg = SEG_DASH;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/shot_annunciator.sv
// Scoreboard output stage: registered digit plus a timed, tone-modulated horn
// fired on the buzz rising edge; the digit blinks while the horn sounds.
module shot_annunciator #(
   parameter int TONE_DIV    = 4,
   parameter int BUZZ_CYCLES = 16,
   parameter int BLINK_DIV   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] count,
   input  logic       shoot,
   input  logic       buzz,
   output logic [6:0] seg,
   output logic       horn,
   output logic       busy
);
   import shot_pkg::*;

   localparam int TONE_W  = cnt_width(TONE_DIV);
   localparam int DUR_W   = cnt_width(BUZZ_CYCLES);
   localparam int BLINK_W = cnt_width(BLINK_DIV);

   localparam logic [TONE_W-1:0]  TONE_LAST  = TONE_W'(TONE_DIV - 1);
   localparam logic [DUR_W-1:0]   DUR_LAST   = DUR_W'(BUZZ_CYCLES - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   state_t             state_r;
   logic               buzz_dly_r;
   logic               shoot_dly_r;
   logic [DUR_W-1:0]   dur_cnt_r;
   logic [TONE_W-1:0]  tone_cnt_r;
   logic [BLINK_W-1:0] blink_cnt_r;
   logic               blink_ph_r;
   logic               horn_r;
   logic               busy_r;
   logic [6:0]         seg_r;

   logic               buzz_rise_s;
   logic               shoot_rise_s;
   logic               tone_wrap_s;
   logic               blink_wrap_s;
   logic               dur_done_s;
   logic               blink_ph_next_s;
   logic [6:0]         digit_s;

   seg7_decode u_decode (
      .digit (count),
      .seg   (digit_s)
   );

   // Edge detection and counter terminal-count flags
   always_comb begin
      buzz_rise_s     = buzz & ~buzz_dly_r;
      shoot_rise_s    = shoot & ~shoot_dly_r;
      tone_wrap_s     = (tone_cnt_r == TONE_LAST);
      blink_wrap_s    = (blink_cnt_r == BLINK_LAST);
      dur_done_s      = (dur_cnt_r == DUR_LAST);
      blink_ph_next_s = blink_ph_r ^ blink_wrap_s;
   end

   // FSM, counters, edge registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         buzz_dly_r  <= 1'b0;
         shoot_dly_r <= 1'b0;
         dur_cnt_r   <= '0;
         tone_cnt_r  <= '0;
         blink_cnt_r <= '0;
         blink_ph_r  <= 1'b0;
         horn_r      <= 1'b0;
         busy_r      <= 1'b0;
         seg_r       <= SEG_OFF;
      end else begin
         buzz_dly_r  <= buzz;
         shoot_dly_r <= shoot;
         // Counters and blink phase rest at zero outside HORN; HORN overrides
         dur_cnt_r   <= '0;
         tone_cnt_r  <= '0;
         blink_cnt_r <= '0;
         blink_ph_r  <= 1'b0;
         horn_r      <= 1'b0;
         seg_r       <= digit_s;
         case (state_r)
            IDLE: begin
               if (shoot_rise_s) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end else if (buzz_rise_s) begin
                  state_r <= HORN;
                  horn_r  <= 1'b1;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            end
            HORN: begin
               if (shoot_rise_s) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end else if (dur_done_s) begin
                  state_r <= COOL;
                  busy_r  <= 1'b1;
               end else begin
                  state_r     <= HORN;
                  busy_r      <= 1'b1;
                  dur_cnt_r   <= dur_cnt_r + DUR_W'(1);
                  tone_cnt_r  <= tone_wrap_s  ? '0 : tone_cnt_r + TONE_W'(1);
                  blink_cnt_r <= blink_wrap_s ? '0 : blink_cnt_r + BLINK_W'(1);
                  horn_r      <= tone_wrap_s ? ~horn_r : horn_r;
                  blink_ph_r  <= blink_ph_next_s;
                  seg_r       <= blink_ph_next_s ? SEG_OFF : digit_s;
               end
            end
            COOL: begin
               // Hold off a retrigger until buzz has been seen low
               if (shoot_rise_s || !buzz) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= COOL;
                  busy_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign seg  = seg_r;
   assign horn = horn_r;
   assign busy = busy_r;

endmodule

// File: tb/tb_shot_annunciator.sv
// Self-checking bench for shot_annunciator: vector table plus hand-built horn
// sequences, checked through an expected-result queue.
module tb_shot_annunciator;

   localparam int TONE_DIV    = 4;
   localparam int BUZZ_CYCLES = 16;
   localparam int BLINK_DIV   = 8;

   typedef struct {
      logic [3:0] count;
      logic       shoot;
      logic       buzz;
      logic [6:0] seg;
      logic       horn;
      logic       busy;
   } vec_t;

   typedef struct {
      logic [6:0] seg;
      logic       horn;
      logic       busy;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] count;
   logic       shoot;
   logic       buzz;
   logic [6:0] seg;
   logic       horn;
   logic       busy;

   int n_checks;
   int n_fail;

   exp_t exp_q[$];
   vec_t tab[$];

   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

   shot_annunciator #(
      .TONE_DIV    (TONE_DIV),
      .BUZZ_CYCLES (BUZZ_CYCLES),
      .BLINK_DIV   (BLINK_DIV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .count (count),
      .shoot (shoot),
      .buzz  (buzz),
      .seg   (seg),
      .horn  (horn),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_now(input string name, input logic [6:0] eseg,
                            input logic ehorn, input logic ebusy);
      n_checks++;
      if (seg !== eseg || horn !== ehorn || busy !== ebusy) begin
         n_fail++;
         $display("FAIL %s: got seg=%h horn=%b busy=%b, want seg=%h horn=%b busy=%b",
                  name, seg, horn, busy, eseg, ehorn, ebusy);
      end
   endtask

   // Drive one vector just after a falling edge, compare one cycle later
   task automatic apply(input vec_t v, input string name);
      exp_t e;
      count = v.count;
      shoot = v.shoot;
      buzz  = v.buzz;
      e.seg  = v.seg;
      e.horn = v.horn;
      e.busy = v.busy;
      exp_q.push_back(e);
      @(negedge clk);
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = exp_q.pop_front();
         check_now(name, e.seg, e.horn, e.busy);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] c, input logic s, input logic b,
                               input logic [6:0] es, input logic eh, input logic eb);
      vec_t v;
      v.count = c; v.shoot = s; v.buzz = b;
      v.seg = es; v.horn = eh; v.busy = eb;
      return v;
   endfunction

   // Horn cycle c (0-based from the cycle after the rise): 4 on, 4 off
   function automatic logic horn_at(input int c);
      return ((c / TONE_DIV) % 2) == 0;
   endfunction

   function automatic logic [6:0] seg_at(input int c, input logic [3:0] cnt);
      logic [6:0] g;
      g = glyph[cnt];
      return (((c / BLINK_DIV) % 2) == 1) ? 7'h00 : g;
   endfunction

   // Push a full horn with buzz held high for hold cycles, then buzz low
   task automatic push_full_horn(input logic [3:0] cnt, input int hold);
      for (int c = 0; c < hold; c++) begin
         if (c < BUZZ_CYCLES) begin
            tab.push_back(mk(cnt, 1'b0, 1'b1, seg_at(c, cnt), horn_at(c), 1'b1));
         end else begin
            tab.push_back(mk(cnt, 1'b0, 1'b1, glyph[cnt], 1'b0, 1'b1));
         end
      end
      tab.push_back(mk(cnt, 1'b0, 1'b0, glyph[cnt], 1'b0, 1'b0));
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n = 1'b0;
      count = 4'd0;
      shoot = 1'b0;
      buzz  = 1'b0;

      // Reset state, with count moving underneath
      @(negedge clk);
      count = 4'd7;
      @(negedge clk);
      check_now("reset", 7'h00, 1'b0, 1'b0);
      rst_n = 1'b1;

      // Decode sweep followed by a full horn held for 40 cycles
      for (int i = 0; i < 16; i++) begin
         tab.push_back(mk(4'(i), 1'b0, 1'b0, glyph[i], 1'b0, 1'b0));
      end
      push_full_horn(4'd0, 40);
      for (int i = 0; i < tab.size(); i++) begin
         apply(tab[i], (i < 16) ? "decode" : "full_horn");
      end

      // Cancel: shoot rises five cycles after buzz
      for (int c = 0; c < 5; c++) begin
         apply(mk(4'd5, 1'b0, 1'b1, 7'h6D, horn_at(c), 1'b1), "cancel_pre");
      end
      apply(mk(4'd5, 1'b1, 1'b1, 7'h6D, 1'b0, 1'b0), "cancel_edge");
      for (int c = 0; c < 5; c++) begin
         apply(mk(4'd5, 1'b1, 1'b1, 7'h6D, 1'b0, 1'b0), "cancel_noretrig");
      end
      apply(mk(4'd5, 1'b0, 1'b0, 7'h6D, 1'b0, 1'b0), "cancel_release");

      // Simultaneous buzz and shoot rises: shoot wins
      for (int c = 0; c < 3; c++) begin
         apply(mk(4'd2, 1'b1, 1'b1, 7'h5B, 1'b0, 1'b0), "simultaneous");
      end
      apply(mk(4'd2, 1'b0, 1'b0, 7'h5B, 1'b0, 1'b0), "simul_release");

      // Buzz re-pulsed mid-horn has no effect; horn still ends on time
      for (int c = 0; c < BUZZ_CYCLES; c++) begin
         apply(mk(4'd8, 1'b0, (c == 6) ? 1'b0 : 1'b1, seg_at(c, 4'd8), horn_at(c), 1'b1),
               "no_retrigger");
      end
      apply(mk(4'd8, 1'b0, 1'b1, 7'h7F, 1'b0, 1'b1), "cool_hold");
      apply(mk(4'd8, 1'b0, 1'b0, 7'h7F, 1'b0, 1'b0), "cool_exit");
      // Rearm: second full horn
      tab.delete();
      push_full_horn(4'd9, BUZZ_CYCLES + 2);
      for (int i = 0; i < tab.size(); i++) begin
         apply(tab[i], "rearm");
      end

      // Async reset mid-horn, between clock edges
      for (int c = 0; c < 3; c++) begin
         apply(mk(4'd3, 1'b0, 1'b1, 7'h4F, 1'b1, 1'b1), "pre_reset_horn");
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_now("async_reset", 7'h00, 1'b0, 1'b0);
      @(negedge clk);
      check_now("reset_held", 7'h00, 1'b0, 1'b0);
      // Buzz already high at release counts as a rise
      rst_n = 1'b1;
      apply(mk(4'd3, 1'b0, 1'b1, 7'h4F, 1'b1, 1'b1), "buzz_at_release");
      apply(mk(4'd3, 1'b1, 1'b1, 7'h4F, 1'b0, 1'b0), "final_cancel");
      apply(mk(4'd3, 1'b0, 1'b0, 7'h4F, 1'b0, 1'b0), "final_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
